// File: rtl/cpu_program_loader.sv
// Boot/reload sequencer: takes a length-prefixed byte stream from a host and writes it
// into CPU instruction memory, holding the CPU in reset until the image is complete.
module cpu_program_loader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ins_write,
    output logic [ADDR_W-1:0] ins_addr,
    output logic [7:0]        instruction_write_data,
    output logic              cpu_reset,
    output logic              ins_read,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned HC_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LEN, LOAD, HOLD, RUN} state_t;

    state_t            state, state_nxt;
    logic [8:0]        remain;
    logic [ADDR_W-1:0] idx;
    logic [TO_W-1:0]   to_cnt;
    logic [HC_W-1:0]   hold_cnt;
    logic              accept, len_bad, last_byte, to_expire, hold_end;

    assign in_ready  = (state == LEN) || (state == LOAD);
    assign busy      = in_ready || (state == HOLD);
    assign cpu_reset = (state != RUN);
    assign ins_read  = (state == RUN);

    assign accept    = in_valid && in_ready;
    assign len_bad   = (in_data == 8'd0) || ({24'd0, in_data} > 32'(MEM_DEPTH));
    assign last_byte = (remain == 9'd1);
    // Expires at the end of the TIMEOUT-th consecutive cycle without an accept.
    assign to_expire = !accept && (to_cnt == TO_W'(TIMEOUT - 1));
    assign hold_end  = (hold_cnt == HC_W'(RST_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LEN;
            LEN: begin
                if (accept)         state_nxt = len_bad ? IDLE : LOAD;
                else if (to_expire) state_nxt = IDLE;
            end
            LOAD: begin
                if (accept && last_byte) state_nxt = HOLD;
                else if (to_expire)      state_nxt = IDLE;
            end
            HOLD: if (hold_end) state_nxt = RUN;
            RUN:  if (start) state_nxt = LEN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ins_write              <= 1'b0;
            ins_addr               <= '0;
            instruction_write_data <= 8'd0;
            done                   <= 1'b0;
            err                    <= 1'b0;
            remain                 <= 9'd0;
            idx                    <= '0;
            to_cnt                 <= '0;
            hold_cnt               <= '0;
        end else begin
            ins_write <= (state == LOAD) && accept;
            done      <= (state == HOLD) && hold_end;

            if ((state == LEN) && accept) begin
                remain <= {1'b0, in_data};
                idx    <= '0;
            end
            // The write lands one cycle after the accept; address only moves on writes.
            if ((state == LOAD) && accept) begin
                ins_addr               <= idx;
                instruction_write_data <= in_data;
                idx                    <= idx + ADDR_W'(1);
                remain                 <= remain - 9'd1;
            end

            if ((state_nxt != state) || accept) to_cnt <= '0;
            else if (in_ready)                  to_cnt <= to_cnt + TO_W'(1);

            if (state == HOLD) hold_cnt <= hold_cnt + HC_W'(1);
            else               hold_cnt <= '0;

            if (((state == IDLE) || (state == RUN)) && start)
                err <= 1'b0;
            else if (((state == LEN) && accept && len_bad) || (in_ready && to_expire))
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader: directed scenarios plus random loads checked against
// a transaction-level model of the expected memory image and CPU release sequence.
module tb_cpu_program_loader;
    localparam int DEPTH = 8;
    localparam int RSTC  = 2;
    localparam int TOUT  = 1024;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, ins_write, cpu_reset, ins_read, busy, done, err;
    logic [7:0] ins_addr, instruction_write_data;

    cpu_program_loader #(.ADDR_W(8), .MEM_DEPTH(DEPTH), .RST_CYCLES(RSTC), .TIMEOUT(TOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ins_write(ins_write), .ins_addr(ins_addr),
        .instruction_write_data(instruction_write_data), .cpu_reset(cpu_reset),
        .ins_read(ins_read), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t        exp_q[$];
    logic [7:0] prog[$];
    int         total = 0, bad = 0, wr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every write strobe must match the next entry of the expected memory image.
    always @(negedge clk) begin : mon
        wr_t w;
        if (ins_write === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(ins_addr), 32'(w.a));
                check("wr_data", 32'(instruction_write_data), 32'(w.d));
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_ins_write"}, 32'(ins_write), 32'd0);
        check({tag, "_ins_read"}, 32'(ins_read), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_addr"}, 32'(ins_addr), 32'd0);
        check({tag, "_data"}, 32'(instruction_write_data), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_cpu_reset", 32'(cpu_reset), 32'd1);
        check("start_ins_read", 32'(ins_read), 32'd0);
        check("start_err_clr", 32'(err), 32'd0);
        check("start_ready", 32'(in_ready), 32'd1);
    endtask

    // Returns #1 after the edge on which the byte was accepted.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin
            step();
            check("gap_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n == 50) check("ready_wait", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Model: a length in 1..DEPTH loads that many bytes at addresses 0..L-1, then the CPU
    // is held in reset RSTC cycles from the last write and released with one done pulse.
    task automatic do_load(input int len, input int gap);
        logic [7:0] d;
        pulse_start();
        send(8'(len), gap);
        if (!(len >= 1 && len <= DEPTH)) begin
            check("lenerr_err", 32'(err), 32'd1);
            check("lenerr_busy", 32'(busy), 32'd0);
            check("lenerr_cpu_reset", 32'(cpu_reset), 32'd1);
            check("lenerr_ready", 32'(in_ready), 32'd0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            d = (i < prog.size()) ? prog[i] : 8'($urandom);
            exp_q.push_back({8'(i), d});
            send(d, gap);
            check("write_after_accept", 32'(ins_write), 32'd1);
        end
        for (int r = 0; r < RSTC; r++) begin
            check("hold_cpu_reset", 32'(cpu_reset), 32'd1);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_ins_read", 32'(ins_read), 32'd0);
            check("hold_ready", 32'(in_ready), 32'd0);
            step();
        end
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check("run_ins_read", 32'(ins_read), 32'd1);
        check("run_done", 32'(done), 32'd1);
        check("run_busy", 32'(busy), 32'd0);
        step();
        check("run_done_once", 32'(done), 32'd0);
        check("run_ins_read2", 32'(ins_read), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, len, gap;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        step(); step();
        check_reset_outs("por");
        reset = 1'b0;
        step();
        check("idle_cpu_reset", 32'(cpu_reset), 32'd1);

        // back-to-back stream
        prog = {8'hC9, 8'h0A};
        w0 = wr_cnt;
        do_load(2, 0);
        check("b2b_writes", 32'(wr_cnt - w0), 32'd2);

        // gapped stream
        w0 = wr_cnt;
        do_load(2, 3);
        check("gap_writes", 32'(wr_cnt - w0), 32'd2);

        // bad lengths
        prog.delete();
        w0 = wr_cnt;
        do_load(0, 0);
        do_load(DEPTH + 1, 1);
        do_load(255, 0);
        check("lenerr_no_write", 32'(wr_cnt - w0), 32'd0);

        // timeout after one of three bytes
        pulse_start();
        send(8'd3, 0);
        exp_q.push_back({8'd0, 8'h5A});
        send(8'h5A, 0);
        repeat (TOUT - 1) step();
        check("to_still_busy", 32'(busy), 32'd1);
        check("to_no_err_yet", 32'(err), 32'd0);
        step();
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_ins_read", 32'(ins_read), 32'd0);
        check("to_cpu_reset", 32'(cpu_reset), 32'd1);

        // reload from RUN
        prog = {8'h11, 8'h22};
        do_load(2, 0);
        prog = {8'hFF};
        do_load(1, 1);

        // reset mid-load
        prog.delete();
        pulse_start();
        send(8'd3, 0);
        exp_q.push_back({8'd0, 8'h3C});
        send(8'h3C, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outs("midrst");
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) begin
            check("midrst_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);

        // random loads, some with illegal lengths
        repeat (10) begin
            len = $urandom_range(0, DEPTH + 3);
            gap = $urandom_range(0, 2);
            do_load(len, gap);
        end

        step();
        check("all_writes_seen", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Boot/reload sequencer for the 8-bit CPU's instruction memory.
- Accepts a length-prefixed byte stream from a host over a valid/ready handshake and writes each byte into instruction memory through the CPU's `ins_write` / `instruction_write_data` port.
- Holds the CPU in reset throughout the load, then releases it and enables instruction read (run mode).
- Sits between the host byte source (UART/test harness) and the CPU top level.

Parameters:
- ADDR_W, 8, width of instruction-memory write address.
- MEM_DEPTH, 256, number of instruction-memory locations; a program longer than this is an error.
- RST_CYCLES, 2, cycles the CPU reset is held after the last write (>=1).
- TIMEOUT, 1024, max consecutive cycles without an accepted byte while loading (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a (re)load.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte.
- ins_write  out  1  instruction-memory write strobe.
- ins_addr  out  ADDR_W  write address.
- instruction_write_data  out  8  write data.
- cpu_reset  out  1  drives CPU reset.
- ins_read  out  1  enables CPU instruction fetch.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on entry to RUN.
- err  out  1  sticky load error.

Behaviour:
- One clock (`clk`); `reset` is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - in_ready = ins_write = ins_read = busy = done = err = 0.
  - ins_addr = 0, instruction_write_data = 0.
  - cpu_reset = 1.
- States: IDLE, LEN, LOAD, HOLD, RUN.
- Handshake:
  - A byte is accepted only when in_valid & in_ready are both high in the same cycle.
  - in_data must be stable while in_valid is high and in_ready is low.
  - in_ready = 1 only in LEN and LOAD.
- IDLE:
  - cpu_reset = 1, ins_read = 0.
  - start = 1 -> LEN next cycle; err cleared.
- LEN:
  - Accepted byte L is the program length.
  - L = 0 or L > MEM_DEPTH -> err = 1, go to IDLE.
  - Otherwise store L, index = 0, go to LOAD.
- LOAD, write timing:
  - A byte accepted in cycle t produces, in cycle t+1: ins_write = 1 for exactly one cycle, ins_addr = index, instruction_write_data = byte.
  - index then increments.
  - Back-to-back accepts give consecutive write cycles.
- LOAD, exit:
  - When the L-th byte is accepted -> HOLD.
  - Its write occurs in the first HOLD cycle.
- HOLD:
  - cpu_reset = 1 for exactly RST_CYCLES cycles, counted from HOLD entry.
  - Then -> RUN.
- RUN:
  - cpu_reset = 0, ins_read = 1.
  - done = 1 in the first RUN cycle only.
  - start = 1 -> LEN next cycle; in that cycle cpu_reset = 1 and ins_read = 0.
- busy = 1 in LEN, LOAD, HOLD.
- cpu_reset = 1 in every state except RUN.
- start while in LEN, LOAD or HOLD is ignored.
- Timeout:
  - The counter clears on LEN/LOAD entry and on every accepted byte.
  - TIMEOUT consecutive cycles in LEN/LOAD without an accept -> err = 1, go to IDLE.
  - The transition happens at the end of the TIMEOUT-th idle cycle.
  - A partial program stays in memory; the CPU is never released.
- ins_addr holds its last value when ins_write = 0.
- Reset at any time, including mid-LOAD, returns all outputs to their reset values in the next cycle. Writes already issued are not undone.
- ins_write is never asserted outside the cycle after an accept.

Test Plan:
- Reset, start, stream 0x02, 0xC9, 0x0A back-to-back -> writes addr 0 = 0xC9 and addr 1 = 0x0A in consecutive cycles; cpu_reset = 1 for 2 cycles after the 0x0A write cycle begins; then cpu_reset = 0, ins_read = 1, done pulses once.
- Same stream with in_valid deasserted 3 cycles between bytes -> identical writes, exactly two ins_write pulses, no duplicates, busy = 1 throughout.
- Length byte 0x00, then separately 0x05 with MEM_DEPTH = 4 -> err = 1, IDLE, no ins_write, cpu_reset stays 1; next start clears err.
- Length 0x03, one data byte, then no in_valid for 1024 cycles -> err = 1 after exactly 1024 idle cycles, IDLE, ins_read = 0.
- In RUN, pulse start, load 0x01, 0xFF -> cycle after start: cpu_reset = 1, ins_read = 0; write addr 0 = 0xFF; CPU released again.
- Assert reset during LOAD after byte 1 of 3 -> next cycle all outputs at reset values, state IDLE, further in_valid ignored (in_ready = 0).
